text_scroller_param: RTL and testbench
======================================

// Module: text_scroller_param
// PURPOSE
//   Parametrised successor to the 16-char LCD text scroller. Captures an ASCII message burst into a
//   double-buffered RAM and drives a DISP_CHARS-wide window of it, scrolling long messages with
//   begin/end dwell. Sits between the text source (keypad/caller-ID/UART decode) and the display driver.
//   New over the fixed scroller: any window width; sticky overflow; clean abort on a new message; optional bounce.
// PARAMETERS
//   DISP_CHARS        16    window width in characters
//   MAX_LEN           2048  max stored message length in chars (power of 2); ADDR_W = clog2(MAX_LEN)
//   SCROLL_SPEED_CNT  N/A   clk cycles per one-char scroll step (>=DISP_CHARS+2)
//   SCROLL_BEGIN_CNT  N/A   clk cycles to dwell at position 0
//   SCROLL_END_CNT    N/A   clk cycles to dwell at last position (L-DISP_CHARS)
//   PAD_CHAR          8'h20 fill for window slots beyond message end
// PORTS
//   clk               in   1             system clock
//   reset             in   1             asynchronous, active-high reset
//   ascii_data        in   8             message character
//   ascii_data_ready  in   1             high = ascii_data valid; contiguous high run = one message
//   string_data       out  8*DISP_CHARS  window; char at window slot 0 in MSBs [8*DISP_CHARS-1 -: 8]
//   msg_len           out  ADDR_W+1      length of displayed message
//   overflow          out  1             sticky: displayed message was truncated at MAX_LEN
//   scrolling         out  1             high while the message is longer than DISP_CHARS
// BEHAVIOUR
//   Reset: string_data all PAD_CHAR, msg_len 0, overflow 0, scrolling 0, FSM IDLE, write bank 0.
//   Capture: each ready cycle writes ascii_data to back bank at wr_ptr++; chars past MAX_LEN are dropped
//     and set back-bank overflow. The first cycle ready is low ends the message: banks swap, msg_len and
//     overflow latch, FSM -> LOAD at pos 0 from any state (current scroll aborted, no partial frame shown).
//     A new burst may start the cycle after the swap.
//   LOAD: read DISP_CHARS chars (addr pos..pos+D-1; addr >= L gives PAD_CHAR) into a shadow register,
//     1 read/cycle, 1-cycle RAM latency; string_data updates atomically D+1 cycles after LOAD entry.
//     Then: L<=D -> STATIC (scrolling 0); else HOLD_BEGIN (scrolling 1).
//   HOLD_BEGIN: count SCROLL_BEGIN_CNT -> SCROLL_FWD.
//   SCROLL_FWD: every SCROLL_SPEED_CNT cycles read addr pos+D, shift window left one char, pos++;
//     on reaching pos == L-D -> HOLD_END.
//   HOLD_END: count SCROLL_END_CNT -> LOAD with pos 0 (wrap to start).
//   STATIC/IDLE: hold window; leave only on a message end.
//   Window updates only on step or LOAD completion; never mid-shift.
//   Reset mid-operation: everything returns to reset values; partial burst discarded.
// CONFIGURATION
//   SCROLL_BOUNCE_EN defined: HOLD_END -> SCROLL_REV: every SCROLL_SPEED_CNT read addr pos-1,
//     shift window right, pos--; at pos 0 -> HOLD_BEGIN (no LOAD). Undefined: wrap via LOAD as above;
//     SCROLL_REV state not built.
// STRUCTURE
//   text_scroller_pkg: FSM state enum (IDLE, LOAD, STATIC, HOLD_BEGIN, SCROLL_FWD, HOLD_END, SCROLL_REV),
//     PAD default, clog2 function.
//   Sub-module scroller_msg_ram: 2 x MAX_LEN x 8 simple dual-port RAM, bank bit as address MSB,
//     registered read.
//   Top: capture logic, bank swap, pos/dwell counters, FSM, window shift register.
// TESTING (SPEED 30, BEGIN 40, END 40, D=16)
//   Reset, no input -> string_data = {16{8'h20}}, msg_len 0, scrolling 0.
//   Burst DE AD BE EF -> 17 cycles after swap string_data = DEADBEEF followed by 12x 20; scrolling 0; static forever.
//   Burst 00 11..FF FF EE..00 (32) -> window 00..FF, 40-cycle dwell; then 1 shift per 30 cycles;
//     after 16 steps window FF EE..00, 40-cycle dwell; then reload 00..FF.
//   Mid-SCROLL_FWD burst 42 -> window 42 + 15x 20 after 17 cycles, msg_len 1, old text never reappears.
//   MAX_LEN=64, burst of 70 -> msg_len 64, overflow 1; next 8-char message clears overflow.
//   reset asserted mid-scroll -> outputs at reset values that cycle;
//   with SCROLL_BOUNCE_EN the 32-byte case steps back to 00..FF with no reload.

Source files
------------

// File: rtl/text_scroller_pkg.sv
// Shared FSM encoding, pad default and sizing helpers for the text scroller.
package text_scroller_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STATIC,
    ST_HOLD_BEGIN,
    ST_SCROLL_FWD,
    ST_HOLD_END,
    ST_SCROLL_REV
  } state_e;

  localparam logic [7:0] PAD_DEFAULT = 8'h20;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/scroller_msg_ram.sv
// Double-banked message store: bank bit is the address MSB, registered read.
module scroller_msg_ram
  import text_scroller_pkg::*;
#(
  parameter int ADDR_W = 11
) (
  input  logic            clk,
  input  logic            i_we,
  input  logic [ADDR_W:0] i_waddr,
  input  logic [7:0]      i_wdata,
  input  logic [ADDR_W:0] i_raddr,
  output logic [7:0]      o_rdata
);
  logic [7:0] r_mem [2**(ADDR_W+1)];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/text_scroller_param.sv
// Parametrised LCD text scroller with double-buffered capture and dwell timing.
// Define SCROLL_BOUNCE_EN to scroll back instead of reloading at the end.
module text_scroller_param
  import text_scroller_pkg::*;
#(
  parameter int         DISP_CHARS       = 16,
  parameter int         MAX_LEN          = 2048,
  parameter int         SCROLL_SPEED_CNT = 30,
  parameter int         SCROLL_BEGIN_CNT = 40,
  parameter int         SCROLL_END_CNT   = 40,
  parameter logic [7:0] PAD_CHAR         = PAD_DEFAULT,
  localparam int        ADDR_W           = clog2(MAX_LEN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              ascii_data,
  input  logic                    ascii_data_ready,
  output logic [8*DISP_CHARS-1:0] string_data,
  output logic [ADDR_W:0]         msg_len,
  output logic                    overflow,
  output logic                    scrolling
);
  localparam int W     = 8 * DISP_CHARS;
  localparam int AW1   = ADDR_W + 1;
  localparam int CNT_W = clog2(max2(max2(SCROLL_SPEED_CNT, SCROLL_BEGIN_CNT),
                                    max2(SCROLL_END_CNT, DISP_CHARS)) + 1);
  localparam logic [AW1-1:0]   A_MAX  = AW1'(MAX_LEN);
  localparam logic [AW1-1:0]   A_D    = AW1'(DISP_CHARS);
  localparam logic [CNT_W-1:0] C_SPD  = CNT_W'(SCROLL_SPEED_CNT - 1);
  localparam logic [CNT_W-1:0] C_BEG  = CNT_W'(SCROLL_BEGIN_CNT - 1);
  localparam logic [CNT_W-1:0] C_END  = CNT_W'(SCROLL_END_CNT - 1);
  localparam logic [CNT_W-1:0] C_LOAD = CNT_W'(DISP_CHARS);

  state_e           r_state, w_state_nx;
  logic             r_wbank, r_rdy_d, r_bk_ovf, r_ovf, r_scroll, r_rd_pad;
  logic [AW1-1:0]   r_wr_ptr, r_len, r_pos, w_rd_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_shadow, r_win;
  logic [7:0]       w_ram_q, w_rd_char;
  logic             w_msg_end, w_we, w_step_last;
  logic             w_load_done, w_step_fwd, w_step_rev;

  assign w_msg_end   = r_rdy_d & ~ascii_data_ready;
  assign w_we        = ascii_data_ready & (r_wr_ptr < A_MAX);
  assign w_rd_char   = r_rd_pad ? PAD_CHAR : w_ram_q;
  assign w_step_last = (r_cnt == C_SPD);

  assign string_data = r_win;
  assign msg_len     = r_len;
  assign overflow    = r_ovf;
  assign scrolling   = r_scroll;

  scroller_msg_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr ({r_wbank, r_wr_ptr[ADDR_W-1:0]}),
    .i_wdata (ascii_data),
    .i_raddr ({~r_wbank, w_rd_idx[ADDR_W-1:0]}),
    .o_rdata (w_ram_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx  = r_state;
    w_load_done = 1'b0;
    w_step_fwd  = 1'b0;
    w_step_rev  = 1'b0;
    w_rd_idx    = r_pos;
    unique case (r_state)
      ST_LOAD: begin
        w_rd_idx = r_pos + AW1'(r_cnt);
        if (r_cnt == C_LOAD) begin
          w_load_done = 1'b1;
          w_state_nx  = (r_len > A_D) ? ST_HOLD_BEGIN : ST_STATIC;
        end
      end
      ST_HOLD_BEGIN: begin
        if (r_cnt == C_BEG) w_state_nx = ST_SCROLL_FWD;
      end
      ST_SCROLL_FWD: begin
        w_rd_idx = r_pos + A_D;
        if (w_step_last) begin
          w_step_fwd = 1'b1;
          if (r_pos + AW1'(1) == r_len - A_D) w_state_nx = ST_HOLD_END;
        end
      end
      ST_HOLD_END: begin
`ifdef SCROLL_BOUNCE_EN
        if (r_cnt == C_END) w_state_nx = ST_SCROLL_REV;
`else
        if (r_cnt == C_END) w_state_nx = ST_LOAD;
`endif
      end
`ifdef SCROLL_BOUNCE_EN
      ST_SCROLL_REV: begin
        w_rd_idx = r_pos - AW1'(1);
        if (w_step_last) begin
          w_step_rev = 1'b1;
          if (r_pos == AW1'(1)) w_state_nx = ST_HOLD_BEGIN;
        end
      end
`endif
      default: ;
    endcase
    // A finished burst preempts whatever is on screen, mid-frame included
    if (w_msg_end) begin
      w_state_nx  = ST_LOAD;
      w_load_done = 1'b0;
      w_step_fwd  = 1'b0;
      w_step_rev  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wbank  <= 1'b0;
      r_rdy_d  <= 1'b0;
      r_bk_ovf <= 1'b0;
      r_ovf    <= 1'b0;
      r_scroll <= 1'b0;
      r_rd_pad <= 1'b0;
      r_wr_ptr <= '0;
      r_len    <= '0;
      r_pos    <= '0;
      r_cnt    <= '0;
      r_shadow <= '0;
      r_win    <= {DISP_CHARS{PAD_CHAR}};
    end else begin
      r_rdy_d  <= ascii_data_ready;
      r_rd_pad <= (w_rd_idx >= r_len);
      if (w_msg_end) begin
        r_wbank  <= ~r_wbank;
        r_len    <= r_wr_ptr;
        r_ovf    <= r_bk_ovf;
        r_wr_ptr <= '0;
        r_bk_ovf <= 1'b0;
      end else if (ascii_data_ready) begin
        if (w_we) r_wr_ptr <= r_wr_ptr + AW1'(1);
        else      r_bk_ovf <= 1'b1;
      end
      if (w_msg_end || (w_state_nx != r_state) || w_step_fwd || w_step_rev)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + CNT_W'(1);
      if (w_state_nx == ST_LOAD) r_pos <= '0;
      else if (w_step_fwd)       r_pos <= r_pos + AW1'(1);
      else if (w_step_rev)       r_pos <= r_pos - AW1'(1);
      if (r_state == ST_LOAD && r_cnt != '0)
        r_shadow <= {r_shadow[W-9:0], w_rd_char};
      if (w_load_done) begin
        r_win    <= {r_shadow[W-9:0], w_rd_char};
        r_scroll <= (r_len > A_D);
      end else if (w_step_fwd) begin
        r_win <= {r_win[W-9:0], w_rd_char};
      end else if (w_step_rev) begin
        r_win <= {w_rd_char, r_win[W-1:8]};
      end
    end
  end
endmodule

// File: tb/tb_text_scroller_param.sv
// Scoreboard bench for text_scroller_param: window timeline predicted from message contents.
module tb_text_scroller_param;
  localparam int D    = 16;
  localparam int ML   = 64;
  localparam int SPD  = 30;
  localparam int BEG  = 40;
  localparam int ENDC = 40;
  localparam logic [127:0] PADW = {16{8'h20}};

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   ascii_data = 8'h00;
  logic         ascii_data_ready = 1'b0;
  logic [127:0] string_data;
  logic [6:0]   msg_len;
  logic         overflow;
  logic         scrolling;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int           cyc;
    logic [127:0] win;
    int           len;
    logic         ovf;
    logic         scr;
  } exp_t;

  exp_t         sb[$];
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;
  bq_t          pmsg;
  int           pn = 0;
  int           pS = 0;
  bit           pvalid = 1'b0;
  logic [127:0] prev;

  text_scroller_param #(
    .DISP_CHARS       (D),
    .MAX_LEN          (ML),
    .SCROLL_SPEED_CNT (SPD),
    .SCROLL_BEGIN_CNT (BEG),
    .SCROLL_END_CNT   (ENDC),
    .PAD_CHAR         (8'h20)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .ascii_data       (ascii_data),
    .ascii_data_ready (ascii_data_ready),
    .string_data      (string_data),
    .msg_len          (msg_len),
    .overflow         (overflow),
    .scrolling        (scrolling)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [127:0] win_of(bq_t m, int p);
    logic [127:0] w;
    for (int i = 0; i < D; i++)
      w[127-8*i -: 8] = (p + i < m.size()) ? m[p+i] : 8'h20;
    return w;
  endfunction

  function automatic exp_t mk(bq_t m, int n, int t, int p);
    exp_t e;
    e.cyc = t;
    e.win = win_of(m, p);
    e.len = m.size();
    e.ovf = (n > ML);
    e.scr = (m.size() > D);
    return e;
  endfunction

  // Window timeline of message m (swap at S) until horizon H
  task automatic push_events(bq_t m, int n, int S, int H);
    int t, p, L;
    L = m.size();
    t = S + D + 1;
    if (t >= H) return;
    sb.push_back(mk(m, n, t, 0));
    if (L <= D) return;
    p = 0;
    forever begin
      t += BEG;
      while (p < L - D) begin
        t += SPD;
        if (t >= H) return;
        p++;
        sb.push_back(mk(m, n, t, p));
      end
      t += ENDC;
`ifdef SCROLL_BOUNCE_EN
      while (p > 0) begin
        t += SPD;
        if (t >= H) return;
        p--;
        sb.push_back(mk(m, n, t, p));
      end
`else
      t += D + 1;
      if (t >= H) return;
      p = 0;
      sb.push_back(mk(m, n, t, p));
`endif
    end
  endtask

  function automatic bq_t rnd_msg(int n);
    bq_t r;
    for (int i = 0; i < n; i++) r.push_back(8'($urandom));
    return r;
  endfunction

  task automatic chk(string name, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic send(bq_t full, int idle);
    int snew;
    bq_t tr;
    snew = cyc + idle + full.size() + 1;
    if (pvalid) push_events(pmsg, pn, pS, snew);
    for (int i = 0; i < full.size() && i < ML; i++) tr.push_back(full[i]);
    repeat (idle) @(negedge clk);
    foreach (full[i]) begin
      ascii_data = full[i];
      ascii_data_ready = 1'b1;
      @(negedge clk);
    end
    ascii_data_ready = 1'b0;
    pmsg = tr;
    pn = full.size();
    pS = snew;
    pvalid = 1'b1;
  endtask

  task automatic do_reset(int k);
    int r;
    r = cyc + k + 1;
    if (pvalid) push_events(pmsg, pn, pS, r);
    repeat (k) @(negedge clk);
    chk("scrolling_before_reset", 128'(scrolling), 128'(pmsg.size() > D));
    #2 reset = 1'b1;
    #1;
    chk("midrst_string_data", string_data, PADW);
    chk("midrst_msg_len", 128'(msg_len), 128'd0);
    chk("midrst_overflow", 128'(overflow), 128'd0);
    chk("midrst_scrolling", 128'(scrolling), 128'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    pvalid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev = string_data;
    end else begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL window_missing at cyc=%0d: display kept %h, required %h from cyc %0d",
                 cyc, string_data, sb[0].win, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (string_data !== prev) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL window_unexpected at cyc=%0d: got %h, required no change from %h",
                   cyc, string_data, prev);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (e.cyc != cyc || e.win !== string_data || msg_len !== 7'(e.len) ||
              overflow !== e.ovf || scrolling !== e.scr) begin
            errors++;
            $display("FAIL window_event got cyc=%0d win=%h len=%0d ovf=%b scr=%b required cyc=%0d win=%h len=%0d ovf=%b scr=%b",
                     cyc, string_data, msg_len, overflow, scrolling,
                     e.cyc, e.win, e.len, e.ovf, e.scr);
          end
        end
        prev = string_data;
      end
    end
  end

  initial begin
    bq_t m;
    int h;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_string_data", string_data, PADW);
    chk("rst_msg_len", 128'(msg_len), 128'd0);
    chk("rst_overflow", 128'(overflow), 128'd0);
    chk("rst_scrolling", 128'(scrolling), 128'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_string_data", string_data, PADW);

    m = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send(m, 5);
    m = {};
    for (int i = 0; i < 16; i++) m.push_back(8'(i * 17));
    for (int i = 0; i < 16; i++) m.push_back(8'(255 - i * 17));
    send(m, 100);
    send(rnd_msg(32), 700);
    m = '{8'h42};
    send(m, 250);
    send(rnd_msg(70), 100);
    send(rnd_msg(8), 1600);
    for (int i = 0; i < 6; i++)
      send(rnd_msg($urandom_range(1, 80)), $urandom_range(1, 900));
    send(rnd_msg(40), 50);
    do_reset(300);
    send(rnd_msg(5), 3);

    h = cyc + 100;
    push_events(pmsg, pn, pS, h);
    repeat (100) @(negedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 128'(sb.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
